// File: rtl/dcache_flush_unit.sv
// D-cache flush walker: cleans and invalidates every set/way,
// then returns a one-cycle acknowledge to the controller.
module dcache_flush_unit #(
  parameter  int NUM_SETS = 256,
  parameter  int NUM_WAYS = 4,
  localparam int SET_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             flush_ack_o,
  output logic             busy_o,
  output logic             tag_req_o,
  output logic [SET_W-1:0] tag_set_o,
  output logic [WAY_W-1:0] tag_way_o,
  input  logic             tag_valid_i,
  input  logic             tag_dirty_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [SET_W-1:0] wb_set_o,
  output logic [WAY_W-1:0] wb_way_o,
  input  logic             wb_done_i,
  output logic             inv_o,
  output logic [SET_W-1:0] inv_set_o,
  output logic [WAY_W-1:0] inv_way_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WB_REQ,
    S_WB_WAIT,
    S_INV,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [SET_W-1:0] set_q;
  logic [WAY_W-1:0] way_q;
  logic [SET_W-1:0] nxt_set;
  logic [WAY_W-1:0] nxt_way;
  logic             last_way;
  logic             last;
  logic             tag_req_q;
  logic             wb_valid_q;
  logic             inv_q;
  logic             ack_o_q;
  logic             ack_q;
  logic             busy_q;
  logic             clean_hit;

  assign last_way = (way_q == WAY_W'(NUM_WAYS - 1));
  assign last     = last_way && (set_q == SET_W'(NUM_SETS - 1));

  always_comb begin
    nxt_way = last_way ? '0 : way_q + WAY_W'(1);
    nxt_set = last_way ? set_q + SET_W'(1) : set_q;
  end

  // Clean hits are invalidated in the same cycle the tag data returns.
  assign clean_hit = (state_q == S_CHECK) && tag_valid_i && !tag_dirty_i;

  assign flush_ack_o = ack_o_q;
  assign busy_o      = busy_q;
  assign tag_req_o   = tag_req_q;
  assign wb_valid_o  = wb_valid_q;
  assign inv_o       = inv_q | clean_hit;
  assign tag_set_o   = set_q;
  assign tag_way_o   = way_q;
  assign wb_set_o    = set_q;
  assign wb_way_o    = way_q;
  assign inv_set_o   = set_q;
  assign inv_way_o   = way_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      set_q      <= '0;
      way_q      <= '0;
      tag_req_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      inv_q      <= 1'b0;
      ack_o_q    <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tag_req_q <= 1'b0;
      inv_q     <= 1'b0;
      ack_o_q   <= 1'b0;
      // Requester drops flush one cycle late; mask it after ack.
      ack_q     <= ack_o_q;
      unique case (state_q)
        S_IDLE: begin
          if (flush_i && !ack_q) begin
            state_q   <= S_READ;
            set_q     <= '0;
            way_q     <= '0;
            tag_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_READ: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (tag_valid_i && tag_dirty_i) begin
            state_q    <= S_WB_REQ;
            wb_valid_q <= 1'b1;
          end else if (last) begin
            state_q <= S_DONE;
            ack_o_q <= 1'b1;
          end else begin
            state_q   <= S_READ;
            tag_req_q <= 1'b1;
            set_q     <= nxt_set;
            way_q     <= nxt_way;
          end
        end
        S_WB_REQ: begin
          if (wb_ready_i) begin
            state_q    <= S_WB_WAIT;
            wb_valid_q <= 1'b0;
          end
        end
        S_WB_WAIT: begin
          if (wb_done_i) begin
            state_q <= S_INV;
            inv_q   <= 1'b1;
          end
        end
        S_INV: begin
          if (last) begin
            state_q <= S_DONE;
            ack_o_q <= 1'b1;
          end else begin
            state_q   <= S_READ;
            tag_req_q <= 1'b1;
            set_q     <= nxt_set;
            way_q     <= nxt_way;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Randomized bench for dcache_flush_unit against a per-line
// latency schedule model on a 4-set, 2-way cache.
module tb_dcache_flush_unit;

  localparam int NL   = 8;
  localparam int MAXC = 160;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       flush_ack_o;
  logic       busy_o;
  logic       tag_req_o;
  logic [1:0] tag_set_o;
  logic       tag_way_o;
  logic       tag_valid_i;
  logic       tag_dirty_i;
  logic       wb_valid_o;
  logic       wb_ready_i;
  logic [1:0] wb_set_o;
  logic       wb_way_o;
  logic       wb_done_i;
  logic       inv_o;
  logic [1:0] inv_set_o;
  logic       inv_way_o;

  dcache_flush_unit #(
    .NUM_SETS(4),
    .NUM_WAYS(2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .flush_ack_o(flush_ack_o),
    .busy_o     (busy_o),
    .tag_req_o  (tag_req_o),
    .tag_set_o  (tag_set_o),
    .tag_way_o  (tag_way_o),
    .tag_valid_i(tag_valid_i),
    .tag_dirty_i(tag_dirty_i),
    .wb_valid_o (wb_valid_o),
    .wb_ready_i (wb_ready_i),
    .wb_set_o   (wb_set_o),
    .wb_way_o   (wb_way_o),
    .wb_done_i  (wb_done_i),
    .inv_o      (inv_o),
    .inv_set_o  (inv_set_o),
    .inv_way_o  (inv_way_o)
  );

  always #5 clk_i = ~clk_i;

  int vecs = 0;
  int errs = 0;

  bit cv [NL];
  bit cd [NL];
  int cr [NL];
  int cdl[NL];

  bit e_tag [MAXC];
  bit e_wb  [MAXC];
  bit e_inv [MAXC];
  bit e_ack [MAXC];
  bit e_busy[MAXC];
  int e_line[MAXC];
  bit dr    [MAXC];
  bit dd    [MAXC];
  bit quiet [MAXC];
  int cl    [MAXC];
  int ack_c;
  int ndirty;
  int obs_ack;
  int wbn;
  bit mv[NL];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pack(
    logic ack, logic busy, logic tr, logic [1:0] ts, logic tw,
    logic wv, logic [1:0] ws, logic ww,
    logic iv, logic [1:0] is, logic iw);
    return {2'b00, ack, busy,
            tr, tr ? ts : 2'b00, tr ? tw : 1'b0,
            wv, wv ? ws : 2'b00, wv ? ww : 1'b0,
            iv, iv ? is : 2'b00, iv ? iw : 1'b0};
  endfunction

  function automatic logic [15:0] exp_vec(int c);
    logic [1:0] s;
    logic       w;
    s = 2'(e_line[c] >> 1);
    w = 1'(e_line[c] & 1);
    return pack(e_ack[c], e_busy[c], e_tag[c], s, w,
                e_wb[c], s, w, e_inv[c], s, w);
  endfunction

  function automatic logic [15:0] obs_vec();
    return pack(flush_ack_o, busy_o, tag_req_o, tag_set_o, tag_way_o,
                wb_valid_o, wb_set_o, wb_way_o,
                inv_o, inv_set_o, inv_way_o);
  endfunction

  function automatic logic [31:0] raw_outs();
    return {19'd0, flush_ack_o, busy_o, tag_req_o, wb_valid_o, inv_o,
            tag_set_o, tag_way_o, wb_set_o, wb_way_o,
            inv_set_o, inv_way_o};
  endfunction

  // Expected per-cycle schedule: clean/invalid lines take 2 cycles,
  // dirty lines 2 + (r+1) in WB_REQ + d in WB_WAIT + 1 for INV.
  task automatic build();
    int t;
    int acc;
    for (int c = 0; c < MAXC; c++) begin
      e_tag[c] = 0; e_wb[c] = 0; e_inv[c] = 0;
      e_ack[c] = 0; e_busy[c] = 0; e_line[c] = 0;
      dr[c] = 0; dd[c] = 0; quiet[c] = 0; cl[c] = -1;
    end
    t = 1;
    ndirty = 0;
    for (int l = 0; l < NL; l++) begin
      e_tag[t] = 1;
      e_line[t] = l;
      cl[t+1] = l;
      if (cv[l] && cd[l]) begin
        ndirty++;
        acc = t + 2 + cr[l];
        for (int k = t + 2; k <= acc; k++) begin
          e_wb[k] = 1;
          e_line[k] = l;
        end
        dr[acc] = 1;
        dd[acc + cdl[l]] = 1;
        for (int k = t + 2; k <= acc + cdl[l]; k++) quiet[k] = 1;
        e_inv[acc + cdl[l] + 1] = 1;
        e_line[acc + cdl[l] + 1] = l;
        t = acc + cdl[l] + 2;
      end else begin
        if (cv[l]) begin
          e_inv[t+1] = 1;
          e_line[t+1] = l;
        end
        t += 2;
      end
    end
    e_ack[t] = 1;
    for (int c = 1; c <= t; c++) e_busy[c] = 1;
    ack_c = t;
  endtask

  task automatic cfg_all(input bit v, input bit d);
    for (int l = 0; l < NL; l++) begin
      cv[l] = v; cd[l] = d; cr[l] = 0; cdl[l] = 1;
    end
  endtask

  task automatic do_reset_abort();
    #2 rst_ni = 1'b0;
    #1 check("rst_async", raw_outs(), 32'd0);
    flush_i = 1'b0;
    wb_ready_i = 1'b0;
    wb_done_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_hold", raw_outs(), 32'd0);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      check("post_rst", {30'd0, flush_ack_o, busy_o}, 32'd0);
    end
  endtask

  // Entered just after a rising edge; cycle 0 raises flush.
  task automatic run_flush(input int drop_c, input int abort_c);
    int cnt;
    build();
    for (int l = 0; l < NL; l++) mv[l] = cv[l];
    wbn = 0;
    obs_ack = -1;
    for (int c = 0; c <= ack_c + 2; c++) begin
      flush_i = (c < drop_c) && (c <= ack_c + 1);
      wb_ready_i = dr[c] | (!quiet[c] && $urandom_range(0, 3) == 0);
      wb_done_i  = dd[c] | (!quiet[c] && $urandom_range(0, 3) == 0);
      if (cl[c] >= 0) begin
        tag_valid_i = cv[cl[c]];
        tag_dirty_i = cd[cl[c]];
      end else begin
        tag_valid_i = 1'($urandom_range(0, 1));
        tag_dirty_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk_i);
      check($sformatf("cyc%0d", c), {16'd0, obs_vec()},
            {16'd0, exp_vec(c)});
      if (inv_o) mv[{inv_set_o, inv_way_o}] = 0;
      if (wb_valid_o && wb_ready_i) wbn++;
      if (flush_ack_o && obs_ack < 0) obs_ack = c;
      if (c == abort_c) begin
        do_reset_abort();
        return;
      end
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0;
    cnt = 0;
    for (int l = 0; l < NL; l++) cnt += int'(mv[l]);
    check("lines_left", cnt, 0);
    check("wb_count", wbn, ndirty);
  endtask

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    tag_valid_i = 1'b0;
    tag_dirty_i = 1'b0;
    wb_ready_i = 1'b0;
    wb_done_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check("reset", raw_outs(), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    cfg_all(0, 0);
    run_flush(1000, -1);
    check("ack_invalid", obs_ack, 17);

    cfg_all(1, 0);
    run_flush(1000, -1);
    check("ack_clean", obs_ack, 17);

    cfg_all(1, 0);
    cd[3] = 1; cr[3] = 3; cdl[3] = 4;
    run_flush(1000, -1);
    check("ack_dirty", obs_ack, 26);

    cfg_all(1, 0);
    cd[0] = 1; cr[0] = 0; cdl[0] = 5;
    run_flush(1000, 5);
    cfg_all(1, 1);
    run_flush(1000, -1);
    check("ack_after_rst", obs_ack, 8 * 5 + 1);

    cfg_all(1, 0);
    run_flush(5, -1);
    check("ack_drop", obs_ack, 17);

    for (int n = 0; n < 40; n++) begin
      for (int l = 0; l < NL; l++) begin
        cv[l]  = 1'($urandom_range(0, 1));
        cd[l]  = 1'($urandom_range(0, 1));
        cr[l]  = int'($urandom_range(0, 3));
        cdl[l] = int'($urandom_range(1, 4));
      end
      if ($urandom_range(0, 2) == 0)
        run_flush(int'($urandom_range(1, 30)), -1);
      else
        run_flush(1000, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dcache_flush_unit.md
Name: dcache_flush_unit

Overview:
- Responder side of the controller's D-cache flush handshake: receives the level flush request (flush_dcache) and returns a single-cycle acknowledge (flush_dcache_ack) when the whole cache has been cleaned and invalidated.
- Walks every set/way of the write-back D-cache, writes back dirty lines through a valid/ready request plus completion pulse, and invalidates each line.
- Sits between the controller and the D-cache tag array and write-back path.

Parameters:
- NUM_SETS, 256, number of cache sets; power of two, at least 2.
- NUM_WAYS, 4, associativity; power of two, at least 1.
- SET_W, $clog2(NUM_SETS), set index width; derived, do not override.
- WAY_W, (NUM_WAYS>1)?$clog2(NUM_WAYS):1, way index width; derived.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  flush request level from the controller; held until ack.
- flush_ack_o  out  1  one-cycle acknowledge, flush complete.
- busy_o  out  1  high whenever state != IDLE.
- tag_req_o  out  1  tag/state read strobe.
- tag_set_o  out  SET_W  set being read.
- tag_way_o  out  WAY_W  way being read.
- tag_valid_i  in  1  line valid; sampled the cycle after tag_req_o.
- tag_dirty_i  in  1  line dirty; sampled the cycle after tag_req_o.
- wb_valid_o  out  1  write-back request.
- wb_ready_i  in  1  write-back request accepted.
- wb_set_o  out  SET_W  write-back set.
- wb_way_o  out  WAY_W  write-back way.
- wb_done_i  in  1  write-back completed pulse.
- inv_o  out  1  invalidate strobe, one cycle.
- inv_set_o  out  SET_W  invalidate set.
- inv_way_o  out  WAY_W  invalidate way.

Behaviour:
- Reset: state IDLE, index 0. All outputs are 0: flush_ack_o, busy_o, tag_req_o, wb_valid_o, inv_o, and all set/way buses.
- Reset is asynchronous in every state, including mid-walk or mid-write-back. It aborts the walk with no ack; outstanding write-back cleanup is the memory side's responsibility.
- Index counter: {set, way}, way minor, with NUM_SETS*NUM_WAYS entries. It starts at 0 on flush entry. After the final entry (set NUM_SETS-1, way NUM_WAYS-1) it goes to DONE; it never wraps into a second pass.
- FSM states: IDLE, READ, CHECK, WB_REQ, WB_WAIT, INV, DONE.
- IDLE: if flush_i=1 and ack_q=0, go to READ and clear the index. ack_q is flush_ack_o registered; it masks flush_i in the cycle after ack because the requester clears its request one cycle late.
- READ: tag_req_o=1, with tag_set_o/tag_way_o taken from the index. Next state is CHECK.
- CHECK (tag outputs valid):
  - valid and dirty: go to WB_REQ.
  - valid and clean: inv_o=1 this cycle, advance the index, go to READ (or DONE on the last entry).
  - invalid: no inv_o, advance the same way.
- WB_REQ: wb_valid_o=1 with set/way stable. Hold until wb_ready_i=1, then go to WB_WAIT. wb_valid_o must not drop or change before the handshake.
- WB_WAIT: wait for wb_done_i=1, then go to INV. wb_done_i outside WB_WAIT is ignored; the memory side guarantees done comes at least 1 cycle after accept.
- INV: inv_o=1 for the current set/way, advance the index, go to READ (or DONE on the last entry).
- DONE: flush_ack_o=1 for exactly one cycle, then go to IDLE.
- Latency per line: clean or invalid line costs 2 cycles. Dirty line costs 2 + (cycles in WB_REQ, including the accept cycle) + (cycles in WB_WAIT, including the done cycle) + 1.
- flush_i deasserted mid-walk: ignored. The walk completes and still acks.
- flush_i is not re-sampled until IDLE.
- busy_o = (state != IDLE).

Test Plan (NUM_SETS=4, NUM_WAYS=2, flush_i rises and is sampled at cycle 0):
- All lines invalid: READ on odd cycles 1..15, no inv_o, no wb_valid_o. flush_ack_o=1 only at cycle 17, busy_o=0 at cycle 18.
- All lines valid and clean: inv_o pulses at cycles 2,4,...,16 with sets 0,0,1,1,2,2,3,3 and ways 0,1,0,1,... Ack at cycle 17.
- Line (set 1, way 1) dirty, wb_ready_i low for 3 cycles, wb_done_i 4 cycles after accept:
  - wb_valid_o with set 1/way 1 is held stable for 4 cycles.
  - inv_o for set 1/way 1 pulses once, one cycle after wb_done_i.
  - Ack is delayed by exactly 2+4+4+1-2 = 9 cycles relative to the all-clean case (cycle 26).
- flush_i held high through the cycle after ack: no second walk starts, busy_o stays 0. flush_i re-raised 2 cycles later starts a new walk.
- rst_ni asserted while in WB_WAIT: all outputs 0 immediately (asynchronous) and no ack. After release, a fresh flush walks from index 0.
- flush_i dropped at cycle 5: the walk continues and ack still occurs at cycle 17 (all-clean config).
